// File: rtl/multi_port_ram_pkg.sv
// multi_port_ram_pkg
//   Shared constants and helpers for the multi-port RAM.
//   READ_FIRST / WRITE_FIRST select what a same-cycle read observes.
//   lane_lsb() gives the bit offset of a write-mask lane inside a word.
package multi_port_ram_pkg;

    localparam int READ_FIRST  = 0;   // read returns pre-edge contents
    localparam int WRITE_FIRST = 1;   // read returns post-merge contents

    function automatic int lane_lsb(input int lane, input int lane_width);
        return lane * lane_width;
    endfunction

endpackage

// File: rtl/multi_port_ram_read_pipeline.sv
// multi_port_ram_read_pipeline
//   Per-port read return path: READ_LATENCY-deep data + valid shift register.
//   Ports:
//     clock, resetn      - rising-edge clock, async active-low reset
//     capture            - read accepted this edge (stage 0 loads)
//     capture_data       - word to load into stage 0
//     read_data          - last stage data; holds while no new result arrives
//     read_valid         - last stage valid, one cycle per accepted read
module multi_port_ram_read_pipeline #(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             capture,
    input  logic [WIDTH-1:0] capture_data,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid
);

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [WIDTH-1:0]        data_pipe [READ_LATENCY];

    // Data registers only advance behind a valid bit, so the output word
    // keeps the last read result while valid is low.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) data_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= capture;
            if (capture) data_pipe[0] <= capture_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign read_data  = data_pipe[READ_LATENCY-1];
    assign read_valid = vld_pipe[READ_LATENCY-1];

endmodule

// File: rtl/multi_port_ram.sv
// multi_port_ram
//   N-port read/write RAM with per-lane write masks, lowest-index-wins
//   collision resolution, read-first or write-first read capture and a
//   registered read pipeline of READ_LATENCY stages per port.
//   Optional macro MULTI_PORT_RAM_COLLISION_DETECT_EN adds write_collision.
//   Ports:
//     clock, resetn      - rising-edge clock, async active-low reset
//     port_write_enable  - per-port write request
//     port_read_enable   - per-port read request
//     port_address       - per-port address (shared by read and write)
//     port_write_data    - per-port write word
//     port_write_mask    - per-port lane enables, 1 = lane written
//     port_read_data     - per-port registered read word
//     write_collision    - (optional) port lost a lane to a lower port
//     port_read_valid    - per-port read result strobe
module multi_port_ram
    import multi_port_ram_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 64,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int PORTS         = 4,
    parameter int LANE_WIDTH    = 8,
    parameter int LANES         = WIDTH / LANE_WIDTH,
    parameter int READ_LATENCY  = 1,
    parameter int READ_MODE     = READ_FIRST
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [PORTS-1:0]           port_write_enable,
    input  logic [PORTS-1:0]           port_read_enable,
    input  logic [PORTS*ADDRESS_WIDTH-1:0] port_address,
    input  logic [PORTS*WIDTH-1:0]     port_write_data,
    input  logic [PORTS*LANES-1:0]     port_write_mask,
    output logic [PORTS*WIDTH-1:0]     port_read_data,
`ifdef MULTI_PORT_RAM_COLLISION_DETECT_EN
    output logic [PORTS-1:0]           write_collision,
`endif
    output logic [PORTS-1:0]           port_read_valid
);

    logic [PORTS-1:0][ADDRESS_WIDTH-1:0] addr;
    logic [PORTS-1:0][WIDTH-1:0]         wdata;
    logic [PORTS-1:0][LANES-1:0]         mask;
    logic [PORTS-1:0]                    in_range;
    logic [PORTS-1:0][LANES-1:0]         lane_req;   // port wants this lane
    logic [PORTS-1:0][LANES-1:0]         lane_win;   // port actually writes it
    logic [PORTS-1:0][WIDTH-1:0]         rd_word;

    logic [WIDTH-1:0] mem [DEPTH];

    assign addr  = port_address;
    assign wdata = port_write_data;
    assign mask  = port_write_mask;

    always_comb begin
        in_range = '0;
        lane_req = '0;
        for (int p = 0; p < PORTS; p++) begin
            in_range[p] = int'(addr[p]) < DEPTH;
            for (int l = 0; l < LANES; l++)
                lane_req[p][l] = port_write_enable[p] && mask[p][l] && in_range[p];
        end
    end

    // A lane is won unless a lower-index port requests the same lane at the
    // same address; winners are therefore unique per (address, lane).
    always_comb begin
        lane_win = '0;
        for (int p = 0; p < PORTS; p++) begin
            for (int l = 0; l < LANES; l++) begin
                lane_win[p][l] = lane_req[p][l];
                for (int q = 0; q < p; q++)
                    if (lane_req[q][l] && addr[q] == addr[p]) lane_win[p][l] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++)
                for (int l = 0; l < LANES; l++)
                    if (lane_win[p][l])
                        mem[addr[p]][lane_lsb(l, LANE_WIDTH) +: LANE_WIDTH]
                            <= wdata[p][lane_lsb(l, LANE_WIDTH) +: LANE_WIDTH];
        end
    end

    // Read capture word. Write-first overlays every winning lane aimed at
    // the same address, regardless of which port wrote it.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < PORTS; r++) begin
            if (in_range[r]) begin
                rd_word[r] = mem[addr[r]];
                if (READ_MODE == WRITE_FIRST) begin
                    for (int p = 0; p < PORTS; p++)
                        for (int l = 0; l < LANES; l++)
                            if (lane_win[p][l] && addr[p] == addr[r])
                                rd_word[r][lane_lsb(l, LANE_WIDTH) +: LANE_WIDTH]
                                    = wdata[p][lane_lsb(l, LANE_WIDTH) +: LANE_WIDTH];
                end
            end
        end
    end

`ifdef MULTI_PORT_RAM_COLLISION_DETECT_EN
    // Requested but not won means a lower port took the lane.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            write_collision <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++)
                write_collision[p] <= |(lane_req[p] & ~lane_win[p]);
        end
    end
`endif

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        multi_port_ram_read_pipeline #(
            .WIDTH        (WIDTH),
            .READ_LATENCY (READ_LATENCY)
        ) u_read_pipeline (
            .clock        (clock),
            .resetn       (resetn),
            .capture      (port_read_enable[p]),
            .capture_data (rd_word[p]),
            .read_data    (port_read_data[p*WIDTH +: WIDTH]),
            .read_valid   (port_read_valid[p])
        );
    end

endmodule

// File: tb/tb_multi_port_ram.sv
// tb_multi_port_ram
//   Two instances share one stimulus stream: one read-first, one write-first,
//   both with READ_LATENCY=2 and non-power-of-two DEPTH=48. A behavioural
//   memory model predicts each read; a negedge monitor pops per-port queues.
module tb_multi_port_ram;

    localparam int W  = 32;
    localparam int D  = 48;
    localparam int AW = 6;
    localparam int P  = 4;
    localparam int NL = 4;
    localparam int RL = 2;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic [P-1:0]    we, re;
    logic [P*AW-1:0] addr_bus;
    logic [P*W-1:0]  wdata_bus;
    logic [P*NL-1:0] mask_bus;
    logic [P*W-1:0]  rdata [2];
    logic [P-1:0]    rvalid [2];
`ifdef MULTI_PORT_RAM_COLLISION_DETECT_EN
    logic [P-1:0]    coll [2];
    logic [P-1:0]    exp_coll [int];
`endif

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    multi_port_ram #(.WIDTH(W), .DEPTH(D), .ADDRESS_WIDTH(AW), .PORTS(P),
        .LANE_WIDTH(8), .LANES(NL), .READ_LATENCY(RL), .READ_MODE(0)) u_rf (
        .clock(clock), .resetn(resetn),
        .port_write_enable(we), .port_read_enable(re), .port_address(addr_bus),
        .port_write_data(wdata_bus), .port_write_mask(mask_bus),
        .port_read_data(rdata[0]),
`ifdef MULTI_PORT_RAM_COLLISION_DETECT_EN
        .write_collision(coll[0]),
`endif
        .port_read_valid(rvalid[0]));

    multi_port_ram #(.WIDTH(W), .DEPTH(D), .ADDRESS_WIDTH(AW), .PORTS(P),
        .LANE_WIDTH(8), .LANES(NL), .READ_LATENCY(RL), .READ_MODE(1)) u_wf (
        .clock(clock), .resetn(resetn),
        .port_write_enable(we), .port_read_enable(re), .port_address(addr_bus),
        .port_write_data(wdata_bus), .port_write_mask(mask_bus),
        .port_read_data(rdata[1]),
`ifdef MULTI_PORT_RAM_COLLISION_DETECT_EN
        .write_collision(coll[1]),
`endif
        .port_read_valid(rvalid[1]));

    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t        q [2][P][$];
    logic [31:0] last [2][P];
    logic [31:0] model_mem [D];

    logic [P-1:0]    s_we, s_re;
    logic [AW-1:0]   s_addr  [P];
    logic [31:0]     s_wdata [P];
    logic [NL-1:0]   s_mask  [P];

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int m, input int p, input logic v, input logic [31:0] d);
        exp_t e;
        if (v) begin
            if (q[m][p].size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_valid mode %0d port %0d @cyc %0d: got data %h, required no valid", m, p, cyc, d);
            end else begin
                e = q[m][p].pop_front();
                check($sformatf("read_data m%0d p%0d", m, p), d, e.data);
                check($sformatf("read_latency m%0d p%0d", m, p), 32'(cyc), 32'(e.due));
                last[m][p] = e.data;
            end
        end else begin
            check($sformatf("data_hold m%0d p%0d", m, p), d, last[m][p]);
            if (q[m][p].size() != 0 && q[m][p][0].due <= cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL missing_valid mode %0d port %0d @cyc %0d: got no valid, required valid at cyc %0d", m, p, cyc, q[m][p][0].due);
                void'(q[m][p].pop_front());
            end
        end
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            for (int m = 0; m < 2; m++)
                for (int p = 0; p < P; p++)
                    mon(m, p, rvalid[m][p], rdata[m][p*W +: W]);
`ifdef MULTI_PORT_RAM_COLLISION_DETECT_EN
            for (int m = 0; m < 2; m++)
                check($sformatf("write_collision m%0d", m), 32'(coll[m]),
                      exp_coll.exists(cyc) ? 32'(exp_coll[cyc]) : 32'd0);
`endif
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic clear_stage();
        s_we = '0; s_re = '0;
        for (int p = 0; p < P; p++) begin
            s_addr[p] = '0; s_wdata[p] = '0; s_mask[p] = '0;
        end
    endtask

    task automatic set_port(input int p, input bit w, input bit r, input int a,
                            input logic [31:0] d, input logic [3:0] m);
        s_we[p] = w; s_re[p] = r; s_addr[p] = AW'(a); s_wdata[p] = d; s_mask[p] = m;
    endtask

    task automatic drive();
        we = s_we; re = s_re;
        for (int p = 0; p < P; p++) begin
            addr_bus[p*AW +: AW]  = s_addr[p];
            wdata_bus[p*W +: W]   = s_wdata[p];
            mask_bus[p*NL +: NL]  = s_mask[p];
        end
    endtask

    // Drive one cycle, predict its effects, then advance past the edge.
    // Writes are applied highest port first so the lowest port lands last.
    task automatic issue();
        logic [31:0]  newmem [D];
        logic [P-1:0] lost;
        exp_t         e;
        drive();
        newmem = model_mem;
        lost = '0;
        for (int p = P - 1; p >= 0; p--)
            if (s_we[p] && int'(s_addr[p]) < D)
                for (int l = 0; l < NL; l++)
                    if (s_mask[p][l]) newmem[s_addr[p]][8*l +: 8] = s_wdata[p][8*l +: 8];
        for (int p = 1; p < P; p++)
            for (int qq = 0; qq < p; qq++)
                if (s_we[p] && s_we[qq] && int'(s_addr[p]) < D && s_addr[p] == s_addr[qq]
                    && (s_mask[p] & s_mask[qq]) != 0)
                    lost[p] = 1'b1;
        for (int p = 0; p < P; p++)
            if (s_re[p]) begin
                e.due  = cyc + RL;
                e.data = (int'(s_addr[p]) < D) ? model_mem[s_addr[p]] : 32'd0;
                q[0][p].push_back(e);
                e.data = (int'(s_addr[p]) < D) ? newmem[s_addr[p]] : 32'd0;
                q[1][p].push_back(e);
            end
`ifdef MULTI_PORT_RAM_COLLISION_DETECT_EN
        if (lost != 0) exp_coll[cyc + 1] = lost;
`else
        if (lost != 0) lost = '0;
`endif
        model_mem = newmem;
        @(posedge clock); #2;
    endtask

    task automatic idle(input int n);
        clear_stage();
        repeat (n) issue();
    endtask

    task automatic do_reset();
        clear_stage();
        drive();
        resetn = 1'b0;
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < P; p++) begin
                q[m][p].delete();
                last[m][p] = '0;
            end
        for (int i = 0; i < D; i++) model_mem[i] = '0;
`ifdef MULTI_PORT_RAM_COLLISION_DETECT_EN
        exp_coll.delete();
`endif
        @(posedge clock); #2;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("reset_valid m%0d", m), 32'(rvalid[m]), 32'd0);
            for (int p = 0; p < P; p++)
                check($sformatf("reset_data m%0d p%0d", m, p), rdata[m][p*W +: W], 32'd0);
`ifdef MULTI_PORT_RAM_COLLISION_DETECT_EN
            check($sformatf("reset_collision m%0d", m), 32'(coll[m]), 32'd0);
`endif
        end
        @(posedge clock); #2;
        resetn = 1'b1;
    endtask

    initial begin
        int base;
        clear_stage();
        drive();
        @(posedge clock); #2;
        do_reset();

        // Fresh memory reads zero.
        clear_stage(); set_port(0, 0, 1, 5, 0, 0); issue();
        idle(RL + 1);

        // Reset while a read is in flight: no valid afterwards.
        clear_stage(); set_port(0, 0, 1, 5, 0, 0); issue();
        do_reset();
        idle(RL + 2);

        // Full-word write then read from another port.
        clear_stage(); set_port(1, 1, 0, 3, 32'hDEADBEEF, 4'hF); issue();
        clear_stage(); set_port(2, 0, 1, 3, 0, 0); issue();
        idle(1);

        // Lane-merged collision on address 7, with a same-cycle reader.
        clear_stage(); set_port(0, 1, 0, 7, 32'h11111111, 4'hF); issue();
        clear_stage();
        set_port(0, 1, 0, 7, 32'hAAAAAAAA, 4'h3);
        set_port(3, 1, 0, 7, 32'hBBBBBBBB, 4'hE);
        set_port(1, 0, 1, 7, 0, 0);
        issue();
        clear_stage(); set_port(2, 0, 1, 7, 0, 0); issue();
        idle(1);

        // Read-during-write on address 9 from a different port.
        clear_stage(); set_port(0, 1, 0, 9, 32'h12345678, 4'hF); issue();
        clear_stage();
        set_port(0, 1, 0, 9, 32'hCAFEF00D, 4'hF);
        set_port(1, 0, 1, 9, 0, 0);
        issue();
        idle(1);

        // Out-of-range address: write dropped, read returns zero with valid.
        clear_stage();
        set_port(2, 1, 0, 50, 32'h55AA55AA, 4'hF);
        set_port(3, 0, 1, 50, 0, 0);
        issue();
        clear_stage(); set_port(3, 1, 1, 47, 32'h0BADF00D, 4'h5); issue();
        clear_stage(); set_port(0, 0, 1, 47, 0, 0); issue();
        idle(1);

        // All ports read distinct addresses every cycle, random writes.
        for (int c = 0; c < 24; c++) begin
            clear_stage();
            base = int'($urandom_range(0, 7));
            for (int p = 0; p < P; p++)
                set_port(p, 1'($urandom_range(0, 1)), 1, (base + p) % 8,
                         $urandom, 4'($urandom_range(0, 15)));
            issue();
        end

        // Dense random traffic with shared addresses to force collisions.
        for (int c = 0; c < 40; c++) begin
            clear_stage();
            for (int p = 0; p < P; p++)
                set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 9) == 0) ? 40 + int'($urandom_range(0, 23))
                                                     : int'($urandom_range(0, 3)),
                         $urandom, 4'($urandom_range(0, 15)));
            issue();
        end

        idle(RL + 2);
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < P; p++)
                check($sformatf("drained m%0d p%0d", m, p), 32'(q[m][p].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
